// File: rtl/call_log_pkg.sv
// Shared types for the call-count logger: the storage-class enum and the
// packed log record that travels through the FIFO.
package call_log_pkg;

  localparam int REC_NUM_TASKS = 4;
  localparam int REC_CNT_W     = 8;
  localparam int REC_DEPTH     = 4;
  localparam int REC_ID_W      = $clog2(REC_NUM_TASKS);

  typedef enum logic {
    STATIC = 1'b0,
    AUTO   = 1'b1
  } storage_e;

  typedef struct packed {
    logic [REC_ID_W-1:0]  id;
    storage_e             auto_cls;
    logic [REC_CNT_W-1:0] count;
  } call_rec_t;

endpackage

// File: rtl/call_rec_fifo.sv
// Synchronous FIFO of call records with a registered head; the head register
// holds its last value whenever the queue runs empty.
module call_rec_fifo
  import call_log_pkg::*;
#(
  parameter int DEPTH = REC_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  call_rec_t push_rec_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output call_rec_t head_rec_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  call_rec_t        mem_q [DEPTH];
  call_rec_t        head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] occupancy;
  logic             do_push, do_pop;

  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign full_o    = (occupancy == PTR_W'(DEPTH));
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  // The next head comes from the slot being written this cycle if the read
  // pointer lands on it, otherwise from storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    head_d   = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      if (do_push && (rd_ptr_d == wr_ptr_q)) begin
        head_d = push_rec_i;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_rec_i;
    end
  end

  assign head_rec_o = head_q;

endmodule

// File: rtl/call_count_logger.sv
// Turns static/automatic call events into the count a `count = count + 1`
// body would print, and queues each result on a valid/ready log stream.
module call_count_logger
  import call_log_pkg::*;
#(
  parameter int NUM_TASKS = REC_NUM_TASKS,
  parameter int CNT_W     = REC_CNT_W,
  parameter int DEPTH     = REC_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         call_valid,
  output logic                         call_ready,
  input  logic [$clog2(NUM_TASKS)-1:0] call_id,
  input  logic                         call_auto,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NUM_TASKS)-1:0] out_id,
  output logic                         out_auto,
  output logic [CNT_W-1:0]             out_count,
  output logic                         wrap_err
);

  logic [CNT_W-1:0] cnt_q [NUM_TASKS];
  logic [CNT_W-1:0] old_cnt, new_cnt;
  logic             wrap_q, wrap_d;
  logic             accept, static_acc;
  logic             fifo_full, fifo_empty;
  call_rec_t        rec_d, head_rec;

  assign call_ready = !rst && !fifo_full;
  assign accept     = call_valid && call_ready;
  assign static_acc = accept && !call_auto;
  assign old_cnt    = cnt_q[call_id];
  assign new_cnt    = old_cnt + CNT_W'(1);

  // Automatic calls behave like a freshly zeroed local, so they always log 1.
  always_comb begin
    rec_d          = '0;
    rec_d.id       = call_id;
    rec_d.auto_cls = call_auto ? AUTO : STATIC;
    rec_d.count    = call_auto ? CNT_W'(1) : new_cnt;
    wrap_d         = wrap_q || (static_acc && (&old_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TASKS; i++) begin
        cnt_q[i] <= '0;
      end
      wrap_q <= 1'b0;
    end else begin
      if (static_acc) begin
        cnt_q[call_id] <= new_cnt;
      end
      wrap_q <= wrap_d;
    end
  end

  call_rec_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (accept),
    .push_rec_i(rec_d),
    .pop_i     (out_ready),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_rec_o(head_rec)
  );

  assign out_valid = !fifo_empty;
  assign out_id    = head_rec.id;
  assign out_auto  = head_rec.auto_cls;
  assign out_count = head_rec.count;
  assign wrap_err  = wrap_q;

endmodule

// File: tb/tb_call_count_logger.sv
// Directed bench for call_count_logger with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_call_count_logger;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       callValid;
  logic       callReady;
  logic [1:0] callId;
  logic       callAuto;
  logic       outValid;
  logic       outReady;
  logic [1:0] outId;
  logic       outAuto;
  logic [7:0] outCount;
  logic       wrapErr;

  typedef struct {
    int id;
    int a;
    int cnt;
  } rec_t;

  rec_t modelQ[$];
  int   modelCnt[4];
  bit   modelWrap;
  rec_t lastShown;
  int   popCnt[$];
  int   popAuto[$];
  int   popId[$];
  bit   compareOn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  call_count_logger dut (
    .clk       (clk),
    .rst       (rst),
    .call_valid(callValid),
    .call_ready(callReady),
    .call_id   (callId),
    .call_auto (callAuto),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_id    (outId),
    .out_auto  (outAuto),
    .out_count (outCount),
    .wrap_err  (wrapErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue holds every record accepted but not yet consumed
  bit   mAcc, mPop;
  rec_t mRec;
  always @(posedge clk) begin
    if (rst) begin
      modelQ.delete();
      for (int i = 0; i < 4; i++) modelCnt[i] = 0;
      modelWrap = 1'b0;
      lastShown = '{0, 0, 0};
    end else begin
      mAcc = callValid && (modelQ.size() < DEPTH);
      mPop = (modelQ.size() > 0) && outReady;
      if (mPop) begin
        popCnt.push_back(modelQ[0].cnt);
        popAuto.push_back(modelQ[0].a);
        popId.push_back(modelQ[0].id);
        void'(modelQ.pop_front());
      end
      if (mAcc) begin
        mRec.id = int'(callId);
        mRec.a  = int'(callAuto);
        if (callAuto) begin
          mRec.cnt = 1;
        end else begin
          if (modelCnt[callId] == 255) modelWrap = 1'b1;
          modelCnt[callId] = (modelCnt[callId] + 1) % 256;
          mRec.cnt = modelCnt[callId];
        end
        modelQ.push_back(mRec);
      end
    end
  end

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("call_ready", callReady, (!rst && modelQ.size() < DEPTH));
      checkOutput("out_valid", outValid, modelQ.size() > 0);
      if (modelQ.size() > 0) lastShown = modelQ[0];
      checkOutput("out_id", outId, lastShown.id);
      checkOutput("out_auto", outAuto, lastShown.a);
      checkOutput("out_count", outCount, lastShown.cnt);
      checkOutput("wrap_err", wrapErr, modelWrap);
    end
  end

  task automatic applyStimulus(input bit v, input int id, input bit a, input bit rdy);
    @(posedge clk);
    #2;
    callValid = v;
    callId    = id[1:0];
    callAuto  = a;
    outReady  = rdy;
  endtask

  task automatic applyReset(input int cycles);
    @(posedge clk);
    #2;
    rst       = 1'b1;
    callValid = 1'b0;
    repeat (cycles) @(posedge clk);
    #2;
    rst = 1'b0;
    popCnt.delete();
    popAuto.delete();
    popId.delete();
  endtask

  task automatic checkLog(input string tag, input int expC[$], input int expA[$], input int expI[$]);
    checkOutput({tag, "_len"}, popCnt.size(), expC.size());
    for (int i = 0; i < expC.size(); i++) begin
      int ac, aa, ai;
      ac = (i < popCnt.size()) ? popCnt[i] : -1;
      aa = (i < popAuto.size()) ? popAuto[i] : -1;
      ai = (i < popId.size()) ? popId[i] : -1;
      checkOutput($sformatf("%s_cnt%0d", tag, i), ac, expC[i]);
      checkOutput($sformatf("%s_auto%0d", tag, i), aa, expA[i]);
      checkOutput($sformatf("%s_id%0d", tag, i), ai, expI[i]);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout reached before end of stimulus");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    callValid = 1'b0;
    callId = 2'd0;
    callAuto = 1'b0;
    outReady = 1'b0;

    // Reset then idle
    applyReset(2);
    compareOn = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", callReady, 1);
    checkOutput("reset_valid", outValid, 0);
    checkOutput("reset_wrap", wrapErr, 0);
    checkOutput("reset_count", outCount, 0);
    checkOutput("reset_id", outId, 0);

    // Static, static, auto, auto on id 0
    applyReset(1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    @(negedge clk);
    checkOutput("latency_valid", outValid, 1);
    checkOutput("latency_count", outCount, 1);
    applyStimulus(1, 0, 1, 1);
    applyStimulus(1, 0, 1, 1);
    repeat (5) applyStimulus(0, 0, 0, 1);
    checkLog("seq_sa", '{1, 2, 1, 1}, '{0, 0, 1, 1}, '{0, 0, 0, 0});

    // Interleaved static ids
    applyReset(1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 2, 0, 1);
    applyStimulus(1, 1, 0, 1);
    repeat (5) applyStimulus(0, 0, 0, 1);
    checkLog("interleave", '{1, 1, 2, 1, 2}, '{0, 0, 0, 0, 0}, '{0, 1, 0, 2, 1});

    // Fill to full with the consumer stalled, then drain
    applyReset(1);
    repeat (5) applyStimulus(1, 1, 0, 0);
    @(negedge clk);
    checkOutput("full_ready", callReady, 0);
    checkOutput("full_head", outCount, 1);
    applyStimulus(0, 1, 0, 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_after_pop", callReady, 1);
    repeat (5) applyStimulus(0, 0, 0, 1);
    checkLog("drain", '{1, 2, 3, 4}, '{0, 0, 0, 0}, '{1, 1, 1, 1});

    // Wrap of a static counter
    applyReset(1);
    repeat (255) applyStimulus(1, 3, 0, 1);
    repeat (4) applyStimulus(0, 3, 0, 1);
    @(negedge clk);
    checkOutput("wrap_before", wrapErr, 0);
    popCnt.delete();
    popAuto.delete();
    popId.delete();
    applyStimulus(1, 3, 0, 1);
    repeat (3) applyStimulus(0, 3, 0, 1);
    @(negedge clk);
    checkOutput("wrap_set", wrapErr, 1);
    applyStimulus(1, 3, 0, 1);
    repeat (3) applyStimulus(0, 3, 0, 1);
    @(negedge clk);
    checkOutput("wrap_sticky", wrapErr, 1);
    checkLog("wrap", '{0, 1}, '{0, 0}, '{3, 3});

    // Reset with records queued
    applyReset(1);
    repeat (3) applyStimulus(1, 2, 0, 0);
    applyStimulus(0, 2, 0, 0);
    @(negedge clk);
    checkOutput("queued_valid", outValid, 1);
    applyReset(1);
    @(negedge clk);
    checkOutput("flush_valid", outValid, 0);
    checkOutput("flush_count", outCount, 0);
    applyStimulus(1, 2, 0, 1);
    repeat (3) applyStimulus(0, 2, 0, 1);
    checkLog("after_flush", '{1}, '{0}, '{2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/call_count_logger.md
Name: call_count_logger

Overview:
- Downstream consumer of task-invocation events from the call-semantics demo stage. Each accepted call event carries a task index and a storage class: static or automatic.
- For each call, the block produces the value a `count = count + 1` body would print. Static calls use one persistent counter per task index. Automatic calls use a fresh zeroed copy every time.
- Each record goes into a small FIFO and is emitted on a valid/ready log stream. A display/scoreboard stage reads that stream.

Parameters:
- NUM_TASKS, 4, number of distinct task indices; each has its own static counter.
- CNT_W, 8, counter and record count width.
- DEPTH, 4, log FIFO depth in records; must be a power of two and ≥ 2.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- call_valid  in  1  call event present.
- call_ready  out  1  block can accept an event this cycle.
- call_id  in  $clog2(NUM_TASKS)  task index.
- call_auto  in  1  1 = automatic, 0 = static.
- out_valid  out  1  head record valid.
- out_ready  in  1  consumer takes the head record.
- out_id  out  $clog2(NUM_TASKS)  task index of the record.
- out_auto  out  1  storage class of the record.
- out_count  out  CNT_W  count value for the record.
- wrap_err  out  1  sticky: a static counter wrapped.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - All static counters clear to 0 and the FIFO empties.
  - out_valid=0, out_id=0, out_auto=0, out_count=0, wrap_err=0.
  - call_ready=0 while rst=1. Events presented during reset are ignored.
  - Reset mid-stream discards every queued record.
- Accept: an event is accepted when call_valid && call_ready. call_ready = !rst && !full and is a pure function of current state; it does not look ahead at a same-cycle pop.
- Static call:
  - count = cnt[call_id] + 1, computed mod 2^CNT_W.
  - cnt[call_id] is updated to count at the same edge.
  - If the old value was all-ones, count = 0 and wrap_err sets. wrap_err stays set until reset.
- Automatic call: count = 1. Static counters are unchanged.
- Back-to-back static calls to the same id on consecutive cycles must each see the previously updated value. No stale read is allowed, e.g. three calls yield 1, 2, 3.
- Record {id, auto, count} is pushed into the FIFO on the accept edge.
- Latency: if the FIFO was empty, out_valid rises on the cycle after accept, with the record fields registered.
- Pop: happens on out_valid && out_ready. The next record, if any, appears the following cycle with no bubble.
- While out_valid=1 && out_ready=0, out_id, out_auto and out_count hold stable.
- When out_valid=0, the out_* data fields hold their last value (0 after reset).
- Simultaneous push and pop with the FIFO non-empty: occupancy is unchanged and ordering is preserved.
- Full: occupancy == DEPTH, so call_ready=0. It rises the cycle after a pop.
- Empty: out_valid=0. out_ready is ignored.
- FIFO read/write pointers carry one extra bit for the full/empty distinction and wrap naturally.

Decomposition:
- Package call_log_pkg holds:
  - typedef call_rec_t, a packed struct {id, auto, count}, parameterised via package localparams that mirror the defaults.
  - The AUTO/STATIC enum for the storage class.
- Sub-module call_rec_fifo: synchronous FIFO of call_rec_t with DEPTH entries, push/pop/full/empty/occupancy, registered outputs.
- The top level holds the counter array, the increment/wrap logic and the handshake glue.

Test Plan:
- Reset then idle → out_valid=0, call_ready=1 one cycle after rst falls, wrap_err=0, all out_* = 0.
- Static, static, auto, auto on id 0 back-to-back with out_ready=1 → out_count sequence 1, 2, 1, 1 and out_auto 0, 0, 1, 1; first out_valid appears 1 cycle after the first accept.
- Interleaved static calls on ids 0, 1, 0, 2, 1 → counts 1, 1, 2, 1, 2, confirming independent per-id counters.
- Hold out_ready=0 and drive 5 static events → 4 accepted, call_ready=0 on the 5th. Head record fields stay stable. Release out_ready → 4 records drain in order, and call_ready returns 1 the cycle after the first pop.
- Preload cnt[3] via 255 static calls (CNT_W=8), then one more → out_count=0, wrap_err=1 and it stays 1. The next call → count 1.
- Assert rst for 1 cycle with 3 records queued → out_valid=0 and queue empty next cycle. A subsequent static call on a previously used id → count 1.
